// File: rtl/regset_dump_6_bit_if.sv
// Handshake/bus bundle for the register-set dump engine.
//   start            : one-cycle dump request (into the engine)
//   ra / rb          : read addresses to the register set's two ports
//   a / b            : combinational read data back from the register set
//   out_valid/ready  : word stream handshake toward the consumer
//   out_addr/data    : the (address, data) word being offered
//   busy / done      : engine status; done is a one-cycle pulse
// The slave modport is the engine; the master modport is everything around it.
interface regset_dump_6_bit_if #(
  parameter int DW = 6,
  parameter int AW = 3
);
  logic          start;
  logic [AW-1:0] ra;
  logic [AW-1:0] rb;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic          busy;
  logic          done;

  modport master (
    output start, a, b, out_ready,
    input  ra, rb, out_valid, out_addr, out_data, busy, done
  );

  modport slave (
    input  start, a, b, out_ready,
    output ra, rb, out_valid, out_addr, out_data, busy, done
  );
endinterface

// File: rtl/regset_dump_6_bit.sv
// Sequential read-out engine for a small register set. On a start pulse it
// fetches two registers per FETCH cycle through the register set's read ports
// and streams each (address, data) word out over valid/ready, ascending.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : slave side of regset_dump_6_bit_if (start, ra/rb, a/b,
//            out_valid/out_ready/out_addr/out_data, busy, done)
// Every output is a flop, so out_valid never depends on out_ready.
module regset_dump_6_bit #(
  parameter int DW       = 6,
  parameter int AW       = 3,
  parameter int NUM_REGS = 5
) (
  input logic               clk,
  input logic               rst_n,
  regset_dump_6_bit_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_SEND0 = 3'd2,
    S_SEND1 = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // One extra bit so idx+1..idx+3 never wrap before being compared.
  localparam logic [AW:0] NUM_W  = (AW+1)'(NUM_REGS);
  localparam logic [AW:0] LAST_W = (AW+1)'(NUM_REGS - 1);

  // Port-B address never points past the last register.
  function automatic logic [AW-1:0] clamp_addr(input logic [AW:0] v);
    logic [AW:0] c;
    if (v > LAST_W) c = LAST_W;
    else            c = v;
    return AW'(c);
  endfunction

  state_t        state_r;
  logic [AW-1:0] idx_r;
  logic [DW-1:0] buf1_r;
  logic          pair2_r;
  logic [AW-1:0] ra_r;
  logic [AW-1:0] rb_r;
  logic          out_valid_r;
  logic [AW-1:0] out_addr_r;
  logic [DW-1:0] out_data_r;   // also serves as the port-A capture buffer
  logic          busy_r;
  logic          done_r;

  logic [AW:0] idx_p1;
  logic [AW:0] idx_p2;
  logic [AW:0] idx_p3;

  assign idx_p1 = {1'b0, idx_r} + (AW+1)'(1);
  assign idx_p2 = {1'b0, idx_r} + (AW+1)'(2);
  assign idx_p3 = {1'b0, idx_r} + (AW+1)'(3);

  // Dump FSM; read addresses and the output word are loaded on the
  // transition into the state that presents them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      idx_r       <= {AW{1'b0}};
      buf1_r      <= {DW{1'b0}};
      pair2_r     <= 1'b0;
      ra_r        <= {AW{1'b0}};
      rb_r        <= {AW{1'b0}};
      out_valid_r <= 1'b0;
      out_addr_r  <= {AW{1'b0}};
      out_data_r  <= {DW{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          idx_r  <= {AW{1'b0}};
          done_r <= 1'b0;
          if (bus.start) begin
            state_r <= S_FETCH;
            busy_r  <= 1'b1;
            ra_r    <= {AW{1'b0}};
            rb_r    <= clamp_addr((AW+1)'(1));
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_FETCH: begin
          // Snapshot both ports; port A goes straight into the output word.
          buf1_r      <= bus.b;
          out_data_r  <= bus.a;
          out_addr_r  <= idx_r;
          out_valid_r <= 1'b1;
          pair2_r     <= (idx_p1 < NUM_W);
          state_r     <= S_SEND0;
        end
        S_SEND0: begin
          if (bus.out_ready) begin
            if (pair2_r) begin
              state_r    <= S_SEND1;
              out_addr_r <= AW'(idx_p1);
              out_data_r <= buf1_r;
            end else begin
              state_r     <= S_DONE;
              out_valid_r <= 1'b0;
              out_addr_r  <= {AW{1'b0}};
              out_data_r  <= {DW{1'b0}};
              ra_r        <= {AW{1'b0}};
              rb_r        <= {AW{1'b0}};
              done_r      <= 1'b1;
            end
          end else begin
            state_r <= S_SEND0;
          end
        end
        S_SEND1: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            if (idx_p2 >= NUM_W) begin
              state_r    <= S_DONE;
              out_addr_r <= {AW{1'b0}};
              out_data_r <= {DW{1'b0}};
              ra_r       <= {AW{1'b0}};
              rb_r       <= {AW{1'b0}};
              done_r     <= 1'b1;
            end else begin
              state_r <= S_FETCH;
              idx_r   <= AW'(idx_p2);
              ra_r    <= AW'(idx_p2);
              rb_r    <= clamp_addr(idx_p3);
            end
          end else begin
            state_r <= S_SEND1;
          end
        end
        S_DONE: begin
          // start is deliberately not looked at here.
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          state_r     <= S_IDLE;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          done_r      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ra        = ra_r;
  assign bus.rb        = rb_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_addr  = out_addr_r;
  assign bus.out_data  = out_data_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;

endmodule

// File: tb/tb_regset_dump_6_bit.sv
// Directed bench for regset_dump_6_bit with a behavioural 5-entry register set.
module tb_regset_dump_6_bit;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   done_cnt;

  logic [5:0] regs [0:4];
  logic [8:0] words_q [$];
  logic [8:0] exp_w [0:4];

  regset_dump_6_bit_if #(.DW(6), .AW(3)) bus ();

  regset_dump_6_bit #(.DW(6), .AW(3), .NUM_REGS(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Combinational register-set read ports.
  assign bus.a = (bus.ra < 3'd5) ? regs[bus.ra] : 6'd0;
  assign bus.b = (bus.rb < 3'd5) ? regs[bus.rb] : 6'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every accepted word and every done pulse.
  always @(posedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) words_q.push_back({bus.out_addr, bus.out_data});
    if (rst_n && bus.done) done_cnt <= done_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic preload(input logic [5:0] r4);
    regs[0] = 6'd7; regs[1] = 6'd6; regs[2] = 6'd5; regs[3] = 6'd12; regs[4] = r4;
    exp_w[0] = {3'd0, 6'd7}; exp_w[1] = {3'd1, 6'd6}; exp_w[2] = {3'd2, 6'd5};
    exp_w[3] = {3'd3, 6'd12}; exp_w[4] = {3'd4, r4};
  endtask

  task automatic test_reset();
    logic [17:0] outs;
    rst_n = 1'b0;
    tick();
    outs = {bus.ra, bus.rb, bus.out_valid, bus.out_addr, bus.out_data, bus.busy, bus.done};
    checks++;
    if (outs !== 18'd0) begin failures++; $display("FAIL reset_outputs: actual=%0h required=0", outs); end
    rst_n = 1'b1;
    tick(); tick();
    outs = {bus.ra, bus.rb, bus.out_valid, bus.out_addr, bus.out_data, bus.busy, bus.done};
    checks++;
    if (outs !== 18'd0) begin failures++; $display("FAIL idle_outputs: actual=%0h required=0", outs); end
  endtask

  task automatic test_basic();
    int exp_valid [9] = '{0, 1, 1, 0, 1, 1, 0, 1, 0};
    int exp_addr  [9] = '{0, 0, 1, 0, 2, 3, 0, 4, 0};
    int exp_data  [9] = '{0, 7, 6, 0, 5, 12, 0, 63, 0};
    int exp_ra    [9] = '{0, 0, 0, 2, 0, 0, 4, 0, 0};
    int exp_rb    [9] = '{1, 0, 0, 3, 0, 0, 4, 0, 0};
    int wbase;
    preload(6'd63);
    bus.out_ready = 1'b1;
    wbase = words_q.size();
    pulse_start();
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (bus.out_valid !== exp_valid[i][0]) begin
        failures++; $display("FAIL basic_valid[%0d]: actual=%0b required=%0b", i, bus.out_valid, exp_valid[i][0]);
      end
      if (exp_valid[i] == 1) begin
        checks++;
        if ({bus.out_addr, bus.out_data} !== {exp_addr[i][2:0], exp_data[i][5:0]}) begin
          failures++; $display("FAIL basic_word[%0d]: actual=%0d/%0d required=%0d/%0d", i, bus.out_addr, bus.out_data, exp_addr[i], exp_data[i]);
        end
      end
      if (i == 0 || i == 3 || i == 6) begin
        checks++;
        if ({bus.ra, bus.rb} !== {exp_ra[i][2:0], exp_rb[i][2:0]}) begin
          failures++; $display("FAIL basic_rarb[%0d]: actual=%0d/%0d required=%0d/%0d", i, bus.ra, bus.rb, exp_ra[i], exp_rb[i]);
        end
      end
      checks++;
      if ({bus.busy, bus.done} !== {1'b1, (i == 8)}) begin
        failures++; $display("FAIL basic_busy_done[%0d]: actual=%0b%0b required=1%0b", i, bus.busy, bus.done, (i == 8));
      end
      tick();
    end
    checks++;
    if ({bus.busy, bus.done, bus.ra, bus.rb} !== 8'd0) begin
      failures++; $display("FAIL basic_after_done: actual=%0h required=0", {bus.busy, bus.done, bus.ra, bus.rb});
    end
    checks++;
    if (words_q.size() - wbase !== 5) begin
      failures++; $display("FAIL basic_count: actual=%0d required=5", words_q.size() - wbase);
    end
    for (int i = 0; i < 5; i++) begin
      if (wbase + i < words_q.size()) begin
        checks++;
        if (words_q[wbase + i] !== exp_w[i]) begin
          failures++; $display("FAIL basic_stream[%0d]: actual=%0h required=%0h", i, words_q[wbase + i], exp_w[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int wbase;
    int dbase;
    bit got;
    preload(6'd63);
    bus.out_ready = 1'b1;
    wbase = words_q.size();
    dbase = done_cnt;
    pulse_start();
    repeat (4) tick();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({bus.out_valid, bus.out_addr, bus.out_data} !== {1'b1, 3'd2, 6'd5}) begin
        failures++; $display("FAIL bp_hold[%0d]: actual=%0b/%0d/%0d required=1/2/5", i, bus.out_valid, bus.out_addr, bus.out_data);
      end
      tick();
    end
    bus.out_ready = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      if (bus.done) got = 1'b1;
      else tick();
    end
    checks++;
    if (!got) begin failures++; $display("FAIL bp_done_timeout: actual=0 required=1"); end
    tick();
    checks++;
    if (words_q.size() - wbase !== 5 || done_cnt - dbase !== 1) begin
      failures++; $display("FAIL bp_count: actual=%0d words %0d done required=5 words 1 done", words_q.size() - wbase, done_cnt - dbase);
    end
    for (int i = 0; i < 5; i++) begin
      if (wbase + i < words_q.size()) begin
        checks++;
        if (words_q[wbase + i] !== exp_w[i]) begin
          failures++; $display("FAIL bp_stream[%0d]: actual=%0h required=%0h", i, words_q[wbase + i], exp_w[i]);
        end
      end
    end
  endtask

  task automatic test_snapshot();
    int wbase;
    bit got;
    preload(6'd63);
    bus.out_ready = 1'b1;
    wbase = words_q.size();
    pulse_start();
    repeat (4) tick();
    regs[3] = 6'd9;
    tick();
    regs[4] = 6'd1;
    exp_w[4] = {3'd4, 6'd1};
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      if (bus.done) got = 1'b1;
      else tick();
    end
    checks++;
    if (!got) begin failures++; $display("FAIL snap_done_timeout: actual=0 required=1"); end
    tick();
    checks++;
    if (words_q.size() - wbase !== 5) begin
      failures++; $display("FAIL snap_count: actual=%0d required=5", words_q.size() - wbase);
    end
    for (int i = 0; i < 5; i++) begin
      if (wbase + i < words_q.size()) begin
        checks++;
        if (words_q[wbase + i] !== exp_w[i]) begin
          failures++; $display("FAIL snap_stream[%0d]: actual=%0h required=%0h", i, words_q[wbase + i], exp_w[i]);
        end
      end
    end
  endtask

  task automatic test_start_while_busy();
    int wbase;
    int dbase;
    preload(6'd63);
    bus.out_ready = 1'b1;
    wbase = words_q.size();
    dbase = done_cnt;
    pulse_start();
    repeat (2) tick();
    pulse_start();
    tick();
    pulse_start();
    repeat (20) tick();
    checks++;
    if (words_q.size() - wbase !== 5 || done_cnt - dbase !== 1) begin
      failures++; $display("FAIL busy_start_count: actual=%0d words %0d done required=5 words 1 done", words_q.size() - wbase, done_cnt - dbase);
    end
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL busy_start_idle: actual=%0b required=0", bus.busy); end
  endtask

  task automatic test_back_to_back();
    int wbase;
    bit got;
    preload(6'd63);
    bus.out_ready = 1'b1;
    pulse_start();
    repeat (8) tick();
    checks++;
    if (bus.done !== 1'b1) begin failures++; $display("FAIL b2b_done_cycle: actual=%0b required=1", bus.done); end
    pulse_start();
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL b2b_start_in_done: actual=%0b required=0", bus.busy); end
    wbase = words_q.size();
    pulse_start();
    checks++;
    if ({bus.busy, bus.ra, bus.rb} !== {1'b1, 3'd0, 3'd1}) begin
      failures++; $display("FAIL b2b_restart: actual=%0b/%0d/%0d required=1/0/1", bus.busy, bus.ra, bus.rb);
    end
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      if (bus.done) got = 1'b1;
      else tick();
    end
    checks++;
    if (!got) begin failures++; $display("FAIL b2b_done_timeout: actual=0 required=1"); end
    tick();
    checks++;
    if (words_q.size() - wbase !== 5) begin
      failures++; $display("FAIL b2b_count: actual=%0d required=5", words_q.size() - wbase);
    end
  endtask

  task automatic test_async_reset();
    int wbase;
    int dbase;
    bit got;
    logic [17:0] outs;
    preload(6'd63);
    bus.out_ready = 1'b1;
    dbase = done_cnt;
    pulse_start();
    repeat (2) tick();
    checks++;
    if ({bus.out_valid, bus.out_addr, bus.out_data} !== {1'b1, 3'd1, 6'd6}) begin
      failures++; $display("FAIL rst_pre_word: actual=%0b/%0d/%0d required=1/1/6", bus.out_valid, bus.out_addr, bus.out_data);
    end
    #2 rst_n = 1'b0;
    #1;
    outs = {bus.ra, bus.rb, bus.out_valid, bus.out_addr, bus.out_data, bus.busy, bus.done};
    checks++;
    if (outs !== 18'd0) begin failures++; $display("FAIL rst_async_outputs: actual=%0h required=0", outs); end
    repeat (2) tick();
    rst_n = 1'b1;
    wbase = words_q.size();
    repeat (3) tick();
    checks++;
    if (done_cnt !== dbase || words_q.size() !== wbase || bus.busy !== 1'b0) begin
      failures++; $display("FAIL rst_abort: actual=%0d done %0d words busy %0b required=0 done 0 words busy 0", done_cnt - dbase, words_q.size() - wbase, bus.busy);
    end
    pulse_start();
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      if (bus.done) got = 1'b1;
      else tick();
    end
    checks++;
    if (!got) begin failures++; $display("FAIL rst_done_timeout: actual=0 required=1"); end
    tick();
    checks++;
    if (words_q.size() - wbase !== 5) begin
      failures++; $display("FAIL rst_count: actual=%0d required=5", words_q.size() - wbase);
    end
    for (int i = 0; i < 5; i++) begin
      if (wbase + i < words_q.size()) begin
        checks++;
        if (words_q[wbase + i] !== exp_w[i]) begin
          failures++; $display("FAIL rst_stream[%0d]: actual=%0h required=%0h", i, words_q[wbase + i], exp_w[i]);
        end
      end
    end
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    done_cnt      = 0;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.out_ready = 1'b0;
    preload(6'd63);
    tick();
    test_reset();
    test_basic();
    test_backpressure();
    test_snapshot();
    test_start_while_busy();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regset_dump_6_bit.md
# regset_dump_6_bit

Sequential read-out engine for the 6-bit, 5-entry register set. On a start pulse it walks every register through the register set's two combinational read ports, fetching two registers per fetch cycle, and streams each `(address, data)` word out over a valid/ready handshake. It sits beside the register set and serves debug/trace and context-save paths, the reader counterpart to the CPU's write port.

## Interface
Parameters:
- `DW`, default 6: register data width.
- `AW`, default 3: register address width.
- `NUM_REGS`, default 5: number of registers dumped, addresses 0..NUM_REGS-1.

Ports:
- `clk`, input, 1: the single clock; all state updates on its rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `start`, input, 1: one-cycle request to begin a dump; ignored unless in IDLE.
- `ra`, output, AW: read address to register-set port A.
- `rb`, output, AW: read address to register-set port B.
- `a`, input, DW: register-set port A data (combinational from `ra`).
- `b`, input, DW: register-set port B data (combinational from `rb`).
- `out_valid`, output, 1: `out_addr`/`out_data` hold a word.
- `out_ready`, input, 1: consumer accepts the word this cycle.
- `out_addr`, output, AW: register index of the current word.
- `out_data`, output, DW: register value of the current word.
- `busy`, output, 1: high in every state except IDLE.
- `done`, output, 1: one-cycle pulse after the last word is accepted.

## Operation
- Internal state: `idx` (AW bits, even pair base), `buf0`/`buf1` (DW each), `pair2` flag, FSM.
- `ra` = `idx`; `rb` = `idx+1`, clamped to NUM_REGS-1. Both are 0 in IDLE and DONE.
- States and transitions:
  - IDLE: `idx`=0. On `start`, go to FETCH.
  - FETCH: 1 cycle. Capture `buf0`<=`a` and `buf1`<=`b`. Set `pair2` = (`idx+1` < NUM_REGS). Go to SEND0.
  - SEND0: `out_valid`=1, `out_addr`=`idx`, `out_data`=`buf0`. On `out_ready`, go to SEND1 if `pair2`, else to DONE.
  - SEND1: `out_valid`=1, `out_addr`=`idx+1`, `out_data`=`buf1`. On `out_ready`, go to DONE if `idx+2` >= NUM_REGS; otherwise `idx`<=`idx+2` and go to FETCH.
  - DONE: `done`=1 for exactly this cycle, then go to IDLE.
- Pair order for NUM_REGS=5 is (0,1), (2,3), (4). Words always leave in ascending address order.
- Snapshot semantics: each pair is sampled in its FETCH cycle. A register write after that cycle is not reflected in the already-captured words. A write to a not-yet-fetched register before its FETCH is reflected.
- `start` while `busy` is ignored; there is no queuing.

## Timing
- Reset (async, `rst_n`=0): FSM=IDLE, `idx`=0, `buf0`=`buf1`=0, `pair2`=0. Outputs: `ra`=`rb`=0, `out_valid`=0, `out_addr`=0, `out_data`=0, `busy`=0, `done`=0. Release is synchronous to the next `clk` edge.
- Reset mid-dump aborts immediately: no `done` pulse, no further words. The next `start` restarts from address 0.
- Latency: with `start` sampled at edge k, FETCH occupies cycle k+1 and the first `out_valid` is high in cycle k+2.
- With `out_ready` held high, a 5-register dump is 9 cycles from FETCH to DONE inclusive (F,S0,S1,F,S0,S1,F,S0,D). `done` is high 9 cycles after the `start` edge.
- Handshake: a word transfers on a rising edge with `out_valid`&`out_ready`.
  - While `out_valid`=1 and `out_ready`=0, `out_addr`/`out_data` stay stable and `out_valid` stays high.
  - `out_valid` never depends combinationally on `out_ready`.
- `out_valid` is 0 in IDLE, FETCH and DONE. `busy`=1 from the cycle after `start` through DONE.
- `start` in the DONE cycle is ignored; `start` in the IDLE cycle that follows DONE is honoured.

## Test plan
- Basic dump: preload R0..R4 = 7,6,5,12,63; `start`=1 for 1 cycle; `out_ready`=1 → words (0,7),(1,6),(2,5),(3,12),(4,63) in consecutive accepted cycles except FETCH gaps; `done` pulses 9 cycles after `start`; `busy` falls the cycle after `done`.
- Backpressure: same preload; `out_ready`=0 for 4 cycles during SEND0 of (2,5) → `out_valid`=1 and (2,5) held stable all 4 cycles; no word lost or duplicated.
- Snapshot: write R3=9 in the SEND0 cycle of (2,x) → (3,12) is emitted. Write R4=1 before the third FETCH → (4,1) is emitted.
- Start while busy: pulse `start` again mid-dump → exactly 5 words, a single `done` pulse.
- Async reset mid-dump: assert `rst_n`=0 during SEND1 of (1,6) → all outputs 0 immediately, no `done`. Release, then `start` → full dump from address 0.
- Address drive: check `ra`/`rb` = 0/1, 2/3, 4/4 in the three FETCH cycles, and 0/0 while idle.
